mem_stage_unit: RTL and testbench
=================================

MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: Reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have EX/MEM-side inputs: BranchIn, MemReadIn, MemWriteIn, RegWriteIn, MemToRegIn, LoadStoreByteIn, LoadStoreHalfIn, NotZeroIn, ZeroIn (1 each); JumpIn (2); BranchTargetAddressIn, ALUIn, MemoryWriteDataIn, PCValueForJALIn (32 each); DestinationRegIn (5).
REQ-004 SHALL have: Stall  out  1  hold EX/MEM and all earlier stages this cycle.
REQ-005 SHALL have: PCSrcOut  out  1  branch taken; BranchTargetOut  out  32  redirect address.
REQ-006 SHALL have data-memory port: MemReq out 1; MemWe out 1; MemAddr out 32; MemWData out 32; MemByteEn out 4; MemAck in 1; MemRData in 32.
REQ-007 SHALL have MEM/WB outputs, all registered: RegWriteOut, MemToRegOut (1); JumpOut (2); ReadDataOut, ALUOut, PCValueForJALOut (32); DestinationRegOut (5); MisalignOut (1).

Function
REQ-008 SHALL implement FSM states IDLE and REQ; reset state IDLE.
REQ-009 Access = MemReadIn | MemWriteIn; if both are set, SHALL treat it as a write.
REQ-010 Non-access instruction in IDLE: Stall=0, MEM/WB outputs load from inputs at next edge (1-cycle latency), ReadDataOut=0.
REQ-011 Aligned access in IDLE: Stall=1; SHALL register MemWe, MemWData, and MemByteEn; next state REQ; MEM/WB loads a bubble (RegWriteOut=0, others 0).
REQ-012 In REQ: MemReq=1; MemAddr, MemWe, MemWData, and MemByteEn SHALL stay stable until MemAck.
REQ-013 In REQ with MemAck=0: Stall=1; a bubble SHALL be loaded into MEM/WB.
REQ-014 In REQ with MemAck=1: Stall=0; MEM/WB loads the instruction with formatted ReadDataOut; next state IDLE. Minimum access latency is 2 cycles.
REQ-015 MemAddr = {ALUIn[31:2],2'b00}; the lane is ALUIn[1:0]; little-endian byte lanes.
REQ-016 Width priority: Byte over Half over Word.
REQ-017 Byte store: MemByteEn = 1 << lane; MemWData = the low byte replicated 4 times.
REQ-018 Half store: MemByteEn = 4'b0011 if ALUIn[1]=0, else 4'b1100; MemWData = the low half replicated 2 times.
REQ-019 Word store: MemByteEn = 4'b1111. Reads SHALL drive MemByteEn = 4'b1111.
REQ-020 Load formatting: byte = selected lane sign-extended; half = selected halfword sign-extended; word = MemRData unchanged.
REQ-021 Misaligned access (half with ALUIn[0]=1, or word with ALUIn[1:0]!=0): no MemReq; Stall=0; bubble into MEM/WB; MisalignOut=1 for exactly one cycle.
REQ-022 PCSrcOut = BranchIn & (NotZeroIn ? ~ZeroIn : ZeroIn), combinational. SHALL be 0 whenever Stall=1.
REQ-023 BranchTargetOut = BranchTargetAddressIn, combinational.
REQ-024 MemReq, Stall, PCSrcOut SHALL be 0 while Reset_n=0.
REQ-025 MemAck while in IDLE SHALL be ignored.

Reset
REQ-026 Reset_n low SHALL immediately force state IDLE, MemReq=0, and all registered outputs to 0, without waiting for a clock edge.
REQ-027 Reset asserted in REQ SHALL abandon the access; no MEM/WB update SHALL occur for it after release.
REQ-028 First edge after release SHALL evaluate the inputs present in IDLE normally.

Verification
REQ-029 Non-access: ALUIn=0x1234, RegWriteIn=1, DestinationRegIn=5 -> next edge ALUOut=0x1234, DestinationRegOut=5, Stall=0 throughout.
REQ-030 Byte load: ALUIn=0x103, MemRData=0x80FF0000, MemAck on the 3rd REQ cycle -> MemAddr=0x100 and Stall=1 for 3 cycles, then ReadDataOut=0xFFFFFF80.
REQ-031 Half store: ALUIn=0x202, MemoryWriteDataIn=0xAAAA1234, ack immediate -> MemByteEn=4'b1100, MemWData=0x12341234, MemWe=1, total 2 cycles.
REQ-032 Misaligned word: ALUIn=0x301, MemReadIn=1 -> MemReq never 1, MisalignOut 1 for one cycle, RegWriteOut=0.
REQ-033 Branch: BranchIn=1, NotZeroIn=1, ZeroIn=0 -> PCSrcOut=1; ZeroIn=1 -> PCSrcOut=0.
REQ-034 Reset mid-REQ: Reset_n low while MemReq=1 -> MemReq=0 the same cycle; after release, a later MemAck produces no write-back.

Source files
------------

// File: rtl/mem_stage_unit.sv
// Memory pipeline stage: issues one data-memory access at a time over a req/ack port,
// stalls the front end while it waits, and formats load data into the MEM/WB register.
module mem_stage_unit (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        BranchIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        LoadStoreByteIn,
  input  logic        LoadStoreHalfIn,
  input  logic        NotZeroIn,
  input  logic        ZeroIn,
  input  logic [1:0]  JumpIn,
  input  logic [31:0] BranchTargetAddressIn,
  input  logic [31:0] ALUIn,
  input  logic [31:0] MemoryWriteDataIn,
  input  logic [31:0] PCValueForJALIn,
  input  logic [4:0]  DestinationRegIn,
  output logic        Stall,
  output logic        PCSrcOut,
  output logic [31:0] BranchTargetOut,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [1:0]  JumpOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUOut,
  output logic [31:0] PCValueForJALOut,
  output logic [4:0]  DestinationRegOut,
  output logic        MisalignOut
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  byteen_q;
  logic [1:0]  lane_q;
  logic        byte_q;
  logic        half_q;

  logic        access;
  logic        misalign;
  logic        start_acc;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_fmt;
  logic        wb_load;
  logic [31:0] wb_rdata;
  logic        branch_cond;

  assign access    = MemReadIn | MemWriteIn;
  // Byte accesses can never be misaligned; half needs bit 0 clear, word needs both clear.
  assign misalign  = access & ~LoadStoreByteIn &
                     (LoadStoreHalfIn ? ALUIn[0] : (ALUIn[1:0] != 2'b00));
  assign start_acc = access & ~misalign;

  always_comb begin
    wr_data = MemoryWriteDataIn;
    byte_en = 4'b1111;
    if (LoadStoreByteIn) begin
      wr_data = {4{MemoryWriteDataIn[7:0]}};
      if (MemWriteIn) byte_en = 4'b0001 << ALUIn[1:0];
    end else if (LoadStoreHalfIn) begin
      wr_data = {2{MemoryWriteDataIn[15:0]}};
      if (MemWriteIn) byte_en = ALUIn[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    rd_byte   = MemRData[{lane_q, 3'b000} +: 8];
    rd_half   = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
    rdata_fmt = MemRData;
    if (byte_q)      rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
    else if (half_q) rdata_fmt = {{16{rd_half[15]}}, rd_half};
  end

  // Reset gates the combinational handshake so nothing escapes while Reset_n is low.
  assign Stall = Reset_n & ((state_q == REQ) ? ~MemAck : start_acc);

  assign branch_cond     = BranchIn & (NotZeroIn ? ~ZeroIn : ZeroIn);
  assign PCSrcOut        = Reset_n & ~Stall & branch_cond;
  assign BranchTargetOut = BranchTargetAddressIn;

  assign MemReq    = (state_q == REQ);
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign MemByteEn = byteen_q;

  assign wb_load  = (state_q == IDLE) ? ~access : MemAck;
  assign wb_rdata = ((state_q == REQ) && !we_q) ? rdata_fmt : 32'd0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q           <= IDLE;
      addr_q            <= 32'd0;
      we_q              <= 1'b0;
      wdata_q           <= 32'd0;
      byteen_q          <= 4'd0;
      lane_q            <= 2'd0;
      byte_q            <= 1'b0;
      half_q            <= 1'b0;
      RegWriteOut       <= 1'b0;
      MemToRegOut       <= 1'b0;
      JumpOut           <= 2'd0;
      ReadDataOut       <= 32'd0;
      ALUOut            <= 32'd0;
      PCValueForJALOut  <= 32'd0;
      DestinationRegOut <= 5'd0;
      MisalignOut       <= 1'b0;
    end else begin
      // Default is a bubble; a completing instruction overrides it below.
      RegWriteOut       <= 1'b0;
      MemToRegOut       <= 1'b0;
      JumpOut           <= 2'd0;
      ReadDataOut       <= 32'd0;
      ALUOut            <= 32'd0;
      PCValueForJALOut  <= 32'd0;
      DestinationRegOut <= 5'd0;
      MisalignOut       <= 1'b0;

      if (state_q == IDLE) begin
        if (start_acc) begin
          state_q  <= REQ;
          addr_q   <= {ALUIn[31:2], 2'b00};
          we_q     <= MemWriteIn;
          wdata_q  <= wr_data;
          byteen_q <= byte_en;
          lane_q   <= ALUIn[1:0];
          byte_q   <= LoadStoreByteIn;
          half_q   <= LoadStoreHalfIn & ~LoadStoreByteIn;
        end else if (misalign) begin
          MisalignOut <= 1'b1;
        end
      end else if (MemAck) begin
        state_q <= IDLE;
      end

      if (wb_load) begin
        RegWriteOut       <= RegWriteIn;
        MemToRegOut       <= MemToRegIn;
        JumpOut           <= JumpIn;
        ReadDataOut       <= wb_rdata;
        ALUOut            <= ALUIn;
        PCValueForJALOut  <= PCValueForJALIn;
        DestinationRegOut <= DestinationRegIn;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed scenarios plus randomized
// back-to-back traffic checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_stage_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        BranchIn, MemReadIn, MemWriteIn, RegWriteIn, MemToRegIn;
  logic        LoadStoreByteIn, LoadStoreHalfIn, NotZeroIn, ZeroIn;
  logic [1:0]  JumpIn;
  logic [31:0] BranchTargetAddressIn, ALUIn, MemoryWriteDataIn, PCValueForJALIn;
  logic [4:0]  DestinationRegIn;
  logic        Stall, PCSrcOut;
  logic [31:0] BranchTargetOut;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemByteEn;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        RegWriteOut, MemToRegOut;
  logic [1:0]  JumpOut;
  logic [31:0] ReadDataOut, ALUOut, PCValueForJALOut;
  logic [4:0]  DestinationRegOut;
  logic        MisalignOut;

  mem_stage_unit dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .BranchIn(BranchIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .LoadStoreByteIn(LoadStoreByteIn), .LoadStoreHalfIn(LoadStoreHalfIn),
    .NotZeroIn(NotZeroIn), .ZeroIn(ZeroIn), .JumpIn(JumpIn),
    .BranchTargetAddressIn(BranchTargetAddressIn), .ALUIn(ALUIn),
    .MemoryWriteDataIn(MemoryWriteDataIn), .PCValueForJALIn(PCValueForJALIn),
    .DestinationRegIn(DestinationRegIn),
    .Stall(Stall), .PCSrcOut(PCSrcOut), .BranchTargetOut(BranchTargetOut),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .JumpOut(JumpOut),
    .ReadDataOut(ReadDataOut), .ALUOut(ALUOut), .PCValueForJALOut(PCValueForJALOut),
    .DestinationRegOut(DestinationRegOut), .MisalignOut(MisalignOut)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int          stall_cnt, req_cnt;
  bit          bus_changed, bubble_bad, pcsrc_bad, timeout;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  // ---------------- reference model ----------------
  function automatic int m_size(bit b, bit h);
    return b ? 1 : (h ? 2 : 4);
  endfunction

  function automatic bit m_mis(bit b, bit h, logic [31:0] a);
    return (a % m_size(b, h)) != 0;
  endfunction

  function automatic logic [3:0] m_be(bit b, bit h, bit wr, logic [31:0] a);
    int unsigned mask;
    if (!wr) return 4'hF;
    mask = (1 << m_size(b, h)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(bit b, bit h, logic [31:0] d);
    if (b) return (d & 32'hFF) * 32'h01010101;
    if (h) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(bit b, bit h, logic [31:0] a, logic [31:0] r);
    logic [31:0] v;
    int unsigned lane;
    lane = a % 4;
    if (b) begin
      v = (r >> (8 * lane)) & 32'hFF;
      if (v >= 128) v = v - 256;
    end else if (h) begin
      v = (r >> (8 * lane)) & 32'hFFFF;
      if (v >= 32768) v = v - 65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_instr(input bit rd, input bit wr, input bit bb, input bit hh,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input bit regw, input logic [4:0] dest);
    MemReadIn = rd; MemWriteIn = wr; LoadStoreByteIn = bb; LoadStoreHalfIn = hh;
    ALUIn = alu; MemoryWriteDataIn = wd; RegWriteIn = regw; DestinationRegIn = dest;
    MemToRegIn = 1'($urandom_range(1, 0));
    JumpIn = 2'($urandom_range(3, 0));
    PCValueForJALIn = $urandom;
    BranchTargetAddressIn = $urandom;
    BranchIn = 1'b0; NotZeroIn = 1'b0; ZeroIn = 1'b0;
  endtask

  // Runs one instruction to completion starting just after a rising edge.
  // The access is acked on REQ cycle ack_delay+1; idle_ack drives MemAck outside REQ.
  task automatic run_instr(input int ack_delay, input bit idle_ack);
    int  req_cyc;
    bit  done, done_now;
    req_cyc = 0; done = 0;
    stall_cnt = 0; req_cnt = 0;
    bus_changed = 0; bubble_bad = 0; pcsrc_bad = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (MemReq) begin
        req_cyc++;
        MemAck = (req_cyc > ack_delay);
      end else begin
        MemAck = idle_ack;
      end
      @(negedge Clk);
      if (Stall) stall_cnt++;
      if (Stall && PCSrcOut) pcsrc_bad = 1;
      if (MemReq) begin
        if (req_cnt == 0) begin
          obs_addr = MemAddr; obs_wdata = MemWData; obs_be = MemByteEn; obs_we = MemWe;
        end else if (MemAddr !== obs_addr || MemWData !== obs_wdata ||
                     MemByteEn !== obs_be || MemWe !== obs_we) begin
          bus_changed = 1;
        end
        req_cnt++;
      end
      done_now = !Stall;
      @(posedge Clk); #1;
      if (done_now) done = 1;
      else if (RegWriteOut || MemToRegOut || JumpOut != 0 || ALUOut != 0 ||
               ReadDataOut != 0 || PCValueForJALOut != 0 || DestinationRegOut != 0)
        bubble_bad = 1;
    end
    timeout = !done;
    MemAck = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    Reset_n = 1'b0; MemAck = 1'b1; MemRData = 32'h1234_5678;
    set_instr(1, 0, 0, 0, 32'h100, 32'h0, 1, 5'd3);
    BranchIn = 1; NotZeroIn = 0; ZeroIn = 1;
    #3;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq got %b exp 0", MemReq); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", Stall); end
    checks++; if (PCSrcOut !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got %b exp 0", PCSrcOut); end
    @(posedge Clk); #1;
    checks++; if (RegWriteOut !== 1'b0 || ALUOut !== 32'd0 || MisalignOut !== 1'b0 || ReadDataOut !== 32'd0)
      begin errors++; $display("FAIL reset_wb got rw=%b alu=%h mis=%b rd=%h exp all 0", RegWriteOut, ALUOut, MisalignOut, ReadDataOut); end
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq_edge got %b exp 0", MemReq); end
    @(negedge Clk);
    MemAck = 1'b0;
    set_instr(0, 0, 0, 0, 32'h55, 32'h0, 1, 5'd9);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++; if (ALUOut !== 32'h55 || DestinationRegOut !== 5'd9 || RegWriteOut !== 1'b1)
      begin errors++; $display("FAIL release_first_edge got alu=%h rd=%0d rw=%b exp 55 9 1", ALUOut, DestinationRegOut, RegWriteOut); end
  endtask

  task automatic test_non_access;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_instr(0, 0, 0, 0, 32'h1234, 32'h0, 1, 5'd5);
      else set_instr(0, 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom,
                     1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)));
      MemRData = $urandom;
      run_instr(0, 1'($urandom_range(1, 0)));
      checks++; if (timeout || stall_cnt != 0 || req_cnt != 0)
        begin errors++; $display("FAIL non_access_stall got stall=%0d req=%0d to=%b exp 0 0 0", stall_cnt, req_cnt, timeout); end
      checks++; if (ALUOut !== ALUIn || DestinationRegOut !== DestinationRegIn || RegWriteOut !== RegWriteIn)
        begin errors++; $display("FAIL non_access_wb got alu=%h rd=%0d rw=%b exp %h %0d %b", ALUOut, DestinationRegOut, RegWriteOut, ALUIn, DestinationRegIn, RegWriteIn); end
      checks++; if (JumpOut !== JumpIn || PCValueForJALOut !== PCValueForJALIn || MemToRegOut !== MemToRegIn || ReadDataOut !== 32'd0 || MisalignOut !== 1'b0)
        begin errors++; $display("FAIL non_access_ctl got j=%0d pc=%h m2r=%b rd=%h mis=%b", JumpOut, PCValueForJALOut, MemToRegOut, ReadDataOut, MisalignOut); end
    end
  endtask

  task automatic test_byte_load;
    set_instr(1, 0, 1, 0, 32'h103, 32'h0, 1, 5'd7);
    BranchIn = 1; NotZeroIn = 0; ZeroIn = 1;
    MemRData = 32'h80FF0000;
    run_instr(2, 1);
    checks++; if (timeout || stall_cnt != 3 || req_cnt != 3)
      begin errors++; $display("FAIL byte_load_cycles got stall=%0d req=%0d to=%b exp 3 3 0", stall_cnt, req_cnt, timeout); end
    checks++; if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0)
      begin errors++; $display("FAIL byte_load_bus got addr=%h be=%b we=%b exp 100 1111 0", obs_addr, obs_be, obs_we); end
    checks++; if (bus_changed || bubble_bad || pcsrc_bad)
      begin errors++; $display("FAIL byte_load_hold got chg=%b bub=%b pcs=%b exp 0 0 0", bus_changed, bubble_bad, pcsrc_bad); end
    checks++; if (ReadDataOut !== 32'hFFFFFF80 || RegWriteOut !== 1'b1 || DestinationRegOut !== 5'd7)
      begin errors++; $display("FAIL byte_load_data got rd=%h rw=%b dst=%0d exp ffffff80 1 7", ReadDataOut, RegWriteOut, DestinationRegOut); end
  endtask

  task automatic test_half_store;
    set_instr(0, 1, 0, 1, 32'h202, 32'hAAAA1234, 0, 5'd0);
    MemRData = 32'hDEADBEEF;
    run_instr(0, 0);
    checks++; if (timeout || stall_cnt != 1 || req_cnt != 1)
      begin errors++; $display("FAIL half_store_cycles got stall=%0d req=%0d to=%b exp 1 1 0", stall_cnt, req_cnt, timeout); end
    checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h12341234 || obs_we !== 1'b1 || obs_addr !== 32'h200)
      begin errors++; $display("FAIL half_store_bus got be=%b wd=%h we=%b addr=%h exp 1100 12341234 1 200", obs_be, obs_wdata, obs_we, obs_addr); end
  endtask

  task automatic test_misalign;
    set_instr(1, 0, 0, 0, 32'h301, 32'h0, 1, 5'd4);
    run_instr(0, 1);
    checks++; if (timeout || req_cnt != 0 || stall_cnt != 0)
      begin errors++; $display("FAIL misalign_req got req=%0d stall=%0d to=%b exp 0 0 0", req_cnt, stall_cnt, timeout); end
    checks++; if (MisalignOut !== 1'b1 || RegWriteOut !== 1'b0 || ALUOut !== 32'd0)
      begin errors++; $display("FAIL misalign_wb got mis=%b rw=%b alu=%h exp 1 0 0", MisalignOut, RegWriteOut, ALUOut); end
    set_instr(0, 0, 0, 0, 32'h77, 32'h0, 1, 5'd2);
    run_instr(0, 0);
    checks++; if (MisalignOut !== 1'b0 || ALUOut !== 32'h77)
      begin errors++; $display("FAIL misalign_one_cycle got mis=%b alu=%h exp 0 77", MisalignOut, ALUOut); end
  endtask

  task automatic test_branch;
    bit exp;
    for (int i = 0; i < 8; i++) begin
      set_instr(0, 0, 0, 0, $urandom, 32'h0, 0, 5'd0);
      BranchIn = 1'(i >> 2); NotZeroIn = 1'(i >> 1); ZeroIn = 1'(i);
      exp = BranchIn && ((NotZeroIn && !ZeroIn) || (!NotZeroIn && ZeroIn));
      @(negedge Clk);
      checks++; if (PCSrcOut !== exp || BranchTargetOut !== BranchTargetAddressIn)
        begin errors++; $display("FAIL branch_%0d got pcsrc=%b tgt=%h exp %b %h", i, PCSrcOut, BranchTargetOut, exp, BranchTargetAddressIn); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    bit rd, wr, bb, hh, acc, mis, idle_ack;
    int d, sz, exp_cyc;
    logic [31:0] alu, exp_rd;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(1, 0)); wr = 1'($urandom_range(1, 0));
      bb = ($urandom_range(2, 0) == 0); hh = 1'($urandom_range(1, 0));
      alu = $urandom;
      sz = m_size(bb, hh);
      if ($urandom_range(2, 0) != 0) alu = alu - (alu % sz);
      set_instr(rd, wr, bb, hh, alu, $urandom, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)));
      MemRData = $urandom;
      d = $urandom_range(3, 0);
      idle_ack = 1'($urandom_range(1, 0));
      acc = rd || wr;
      mis = acc && m_mis(bb, hh, alu);
      exp_cyc = (acc && !mis) ? d + 1 : 0;
      exp_rd = (acc && !wr && !mis) ? m_load(bb, hh, alu, MemRData) : 32'd0;
      run_instr(d, idle_ack);
      checks++; if (timeout || stall_cnt != exp_cyc || req_cnt != exp_cyc)
        begin errors++; $display("FAIL b2b_%0d_cycles got stall=%0d req=%0d to=%b exp %0d", n, stall_cnt, req_cnt, timeout, exp_cyc); end
      checks++; if (MisalignOut !== mis || RegWriteOut !== (mis ? 1'b0 : RegWriteIn) || ALUOut !== (mis ? 32'd0 : alu))
        begin errors++; $display("FAIL b2b_%0d_wb got mis=%b rw=%b alu=%h exp mis=%b", n, MisalignOut, RegWriteOut, ALUOut, mis); end
      checks++; if (ReadDataOut !== exp_rd)
        begin errors++; $display("FAIL b2b_%0d_rdata got %h exp %h", n, ReadDataOut, exp_rd); end
      if (acc && !mis) begin
        checks++; if (obs_addr !== {alu[31:2], 2'b00} || obs_be !== m_be(bb, hh, wr, alu) || obs_we !== wr)
          begin errors++; $display("FAIL b2b_%0d_bus got addr=%h be=%b we=%b exp be=%b we=%b", n, obs_addr, obs_be, obs_we, m_be(bb, hh, wr, alu), wr); end
        if (wr) begin
          checks++; if (obs_wdata !== m_wd(bb, hh, MemoryWriteDataIn))
            begin errors++; $display("FAIL b2b_%0d_wdata got %h exp %h", n, obs_wdata, m_wd(bb, hh, MemoryWriteDataIn)); end
        end
        checks++; if (bus_changed || bubble_bad)
          begin errors++; $display("FAIL b2b_%0d_hold got chg=%b bub=%b exp 0 0", n, bus_changed, bubble_bad); end
      end
    end
  endtask

  task automatic test_reset_mid_req;
    set_instr(1, 0, 0, 0, 32'h400, 32'h0, 1, 5'd12);
    MemAck = 1'b0; MemRData = 32'hDEADBEEF;
    @(posedge Clk); #1;
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL mid_req_enter got memreq=%b exp 1", MemReq); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (MemReq !== 1'b0 || Stall !== 1'b0)
      begin errors++; $display("FAIL mid_req_async got memreq=%b stall=%b exp 0 0", MemReq, Stall); end
    @(posedge Clk);
    @(negedge Clk);
    set_instr(0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0);
    MemAck = 1'b1;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      checks++; if (MemReq !== 1'b0 || RegWriteOut !== 1'b0 || ReadDataOut !== 32'd0 || DestinationRegOut !== 5'd0)
        begin errors++; $display("FAIL mid_req_no_wb_%0d got memreq=%b rw=%b rd=%h dst=%0d exp 0", i, MemReq, RegWriteOut, ReadDataOut, DestinationRegOut); end
    end
    MemAck = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_non_access();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_branch();
    test_back_to_back();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
